// File: rtl/cordic_pkg.sv
// Shared constants, encodings and angle tables for the iterative CORDIC engine.
// Latency: n/a (declarations and pure functions only).
// Backpressure: n/a.
package cordic_pkg;

    // Coordinate system selection. Code 2'b11 is reserved and folds onto circular.
    typedef enum logic [1:0] {
        COORD_LIN  = 2'b00,
        COORD_CIRC = 2'b01,
        COORD_HYP  = 2'b10
    } coord_t;

    // Operating mode: which variable the iterations drive towards zero.
    localparam logic OP_ROT = 1'b0;   // drive z -> 0
    localparam logic OP_VEC = 1'b1;   // drive y -> 0

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_COMP = 2'b10,
        ST_DONE = 2'b11
    } state_t;

    // Q16.16 constants.
    localparam int K_CIRC     = 39797;   // 0.607253 = 1/prod(sqrt(1+2^-2i))
    localparam int K_HYP      = 54275;   // 0.828159 = prod(sqrt(1-2^-2s)) over the repeat sequence
    localparam int K_HYP_INV  = 79134;   // 1.207497 = 1/K_HYP
    localparam int PI         = 205887;
    localparam int HALF_PI    = 102944;

    // Every table entry and every linear step weight fits in 17 unsigned bits.
    localparam int ANGLE_W = 17;

    // atan(2^-i) in Q16.16.
    function automatic logic [ANGLE_W-1:0] atan_lut(input logic [3:0] idx);
        logic [ANGLE_W-1:0] v;
        case (idx)
            4'd0:    v = 17'd51472;
            4'd1:    v = 17'd30386;
            4'd2:    v = 17'd16055;
            4'd3:    v = 17'd8150;
            4'd4:    v = 17'd4091;
            4'd5:    v = 17'd2047;
            4'd6:    v = 17'd1024;
            4'd7:    v = 17'd512;
            4'd8:    v = 17'd256;
            4'd9:    v = 17'd128;
            4'd10:   v = 17'd64;
            4'd11:   v = 17'd32;
            4'd12:   v = 17'd16;
            4'd13:   v = 17'd8;
            4'd14:   v = 17'd4;
            default: v = 17'd2;
        endcase
        return v;
    endfunction

    // atanh(2^-i) in Q16.16; entry 0 is never addressed (hyperbolic starts at shift 1).
    function automatic logic [ANGLE_W-1:0] atanh_lut(input logic [3:0] idx);
        logic [ANGLE_W-1:0] v;
        case (idx)
            4'd0:    v = 17'd0;
            4'd1:    v = 17'd35999;
            4'd2:    v = 17'd16739;
            4'd3:    v = 17'd8235;
            4'd4:    v = 17'd4101;
            4'd5:    v = 17'd2049;
            4'd6:    v = 17'd1024;
            4'd7:    v = 17'd512;
            4'd8:    v = 17'd256;
            4'd9:    v = 17'd128;
            4'd10:   v = 17'd64;
            4'd11:   v = 17'd32;
            4'd12:   v = 17'd16;
            4'd13:   v = 17'd8;
            4'd14:   v = 17'd4;
            default: v = 17'd2;
        endcase
        return v;
    endfunction

    // Fold the raw port encoding onto the three supported coordinate systems.
    function automatic coord_t decode_coord(input logic [1:0] mc);
        coord_t c;
        case (mc)
            2'b00:   c = COORD_LIN;
            2'b10:   c = COORD_HYP;
            default: c = COORD_CIRC;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/cordic_stage.sv
// One CORDIC micro-rotation: x' = x - m*d*(y>>>s), y' = y + d*(x>>>s), z' = z - d*e.
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs.
module cordic_stage
    import cordic_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic signed [WIDTH-1:0] x_i,
    input  logic signed [WIDTH-1:0] y_i,
    input  logic signed [WIDTH-1:0] z_i,
    input  logic        [4:0]       shift_i,
    input  logic signed [WIDTH-1:0] e_i,
    input  logic        [1:0]       m_i,     // coordinate system (coord_t encoding)
    input  logic                    d_i,     // 1: d=+1, 0: d=-1
    output logic signed [WIDTH-1:0] x_o,
    output logic signed [WIDTH-1:0] y_o,
    output logic signed [WIDTH-1:0] z_o
);

    logic signed [WIDTH-1:0] xs;
    logic signed [WIDTH-1:0] ys;

    // Shift-and-add update; m selects whether y feeds back into x and with which sign.
    always_comb begin
        xs = x_i >>> shift_i;
        ys = y_i >>> shift_i;
        x_o = x_i;
        if (m_i == COORD_CIRC) begin
            x_o = d_i ? (x_i - ys) : (x_i + ys);
        end else if (m_i == COORD_HYP) begin
            x_o = d_i ? (x_i + ys) : (x_i - ys);
        end
        y_o = d_i ? (y_i + xs) : (y_i - xs);
        z_o = d_i ? (z_i - e_i) : (z_i + e_i);
    end

endmodule

// File: rtl/cordic_core.sv
// Iterative multi-mode Q16.16 CORDIC (rotation/vectoring; linear, circular, hyperbolic), gain compensated.
// Latency: ITERATIONS+2 edges from the start edge to the edge that raises valid; one op in flight.
// Backpressure: none; enable is only sampled in IDLE, otherwise ignored. QUADRANT_EXT_EN adds circular pre-rotation.
module cordic_core
    import cordic_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int ITERATIONS = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    mode_op,
    input  logic        [1:0]       mode_coord,
    input  logic signed [WIDTH-1:0] x_in,
    input  logic signed [WIDTH-1:0] y_in,
    input  logic signed [WIDTH-1:0] z_in,
    output logic signed [WIDTH-1:0] x_out,
    output logic signed [WIDTH-1:0] y_out,
    output logic signed [WIDTH-1:0] z_out,
    output logic                    valid
);

    localparam logic [4:0] LAST_STEP = 5'(ITERATIONS - 1);
    localparam logic signed [2*WIDTH-1:0] K_CIRC_W    = (2*WIDTH)'(K_CIRC);
    localparam logic signed [2*WIDTH-1:0] K_HYP_INV_W = (2*WIDTH)'(K_HYP_INV);
`ifdef QUADRANT_EXT_EN
    localparam logic signed [WIDTH-1:0] PI_W      = WIDTH'(PI);
    localparam logic signed [WIDTH-1:0] HALF_PI_W = WIDTH'(HALF_PI);
`endif

    state_t                  state_q;
    logic        [4:0]       cnt_q;
    logic        [4:0]       s_q;       // current shift amount
    logic                    rep_q;     // current hyperbolic shift already executed once
    logic                    op_q;
    coord_t                  coord_q;
    logic signed [WIDTH-1:0] x_q, y_q, z_q;
    logic signed [WIDTH-1:0] x_out_q, y_out_q, z_out_q;
    logic                    valid_q;

    // Load-cycle operands (after optional quadrant folding).
    coord_t                  coord_ld;
    logic signed [WIDTH-1:0] x_ld, y_ld, z_ld;

    // Micro-rotation controls and results.
    logic                    d_pos;
    logic        [ANGLE_W-1:0] e_raw;
    logic signed [WIDTH-1:0] e_w;
    logic                    rep_now;
    logic signed [WIDTH-1:0] x_d, y_d, z_d;

    // Gain compensation.
    logic signed [2*WIDTH-1:0] x_ext, y_ext, k_ext, x_prod, y_prod;
    logic signed [WIDTH-1:0]   x_sc, y_sc;

    // Capture path: decode coordinate system and, when enabled, fold circular inputs into range.
    always_comb begin
        coord_ld = decode_coord(mode_coord);
        x_ld     = x_in;
        y_ld     = y_in;
        z_ld     = z_in;
`ifdef QUADRANT_EXT_EN
        if (coord_ld == COORD_CIRC) begin
            if (mode_op == OP_ROT) begin
                if (z_in > HALF_PI_W) begin
                    z_ld = z_in - PI_W;
                    x_ld = -x_in;
                    y_ld = -y_in;
                end else if (z_in < -HALF_PI_W) begin
                    z_ld = z_in + PI_W;
                    x_ld = -x_in;
                    y_ld = -y_in;
                end
            end else if (x_in[WIDTH-1]) begin
                // Rotating by pi puts the vector in the right half-plane; the angle
                // accumulator absorbs the pi with the sign that keeps it in (-pi, pi].
                x_ld = -x_in;
                y_ld = -y_in;
                z_ld = y_in[WIDTH-1] ? (z_in - PI_W) : (z_in + PI_W);
            end
        end
`endif
    end

    // Step controls: direction, angle weight and hyperbolic repeat decision.
    always_comb begin
        d_pos = (op_q == OP_ROT) ? ~z_q[WIDTH-1] : y_q[WIDTH-1];
        case (coord_q)
            COORD_HYP: e_raw = atanh_lut(s_q[3:0]);
            COORD_LIN: e_raw = 17'h10000 >> s_q;
            default:   e_raw = atan_lut(s_q[3:0]);
        endcase
        e_w     = $signed({{(WIDTH-ANGLE_W){1'b0}}, e_raw});
        rep_now = (coord_q == COORD_HYP) && ((s_q == 5'd4) || (s_q == 5'd13)) && !rep_q;
    end

    cordic_stage #(
        .WIDTH (WIDTH)
    ) u_stage (
        .x_i     (x_q),
        .y_i     (y_q),
        .z_i     (z_q),
        .shift_i (s_q),
        .e_i     (e_w),
        .m_i     (coord_q),
        .d_i     (d_pos),
        .x_o     (x_d),
        .y_o     (y_d),
        .z_o     (z_d)
    );

    // Full-width gain multiply; hyperbolic steps shrink the vector, so it scales by 1/K_HYP.
    always_comb begin
        x_ext  = (2*WIDTH)'(x_q);
        y_ext  = (2*WIDTH)'(y_q);
        k_ext  = (coord_q == COORD_HYP) ? K_HYP_INV_W : K_CIRC_W;
        x_prod = x_ext * k_ext;
        y_prod = y_ext * k_ext;
        x_sc   = WIDTH'(x_prod >>> 16);
        y_sc   = WIDTH'(y_prod >>> 16);
    end

    // Control FSM with datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            s_q     <= '0;
            rep_q   <= 1'b0;
            op_q    <= OP_ROT;
            coord_q <= COORD_LIN;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            x_out_q <= '0;
            y_out_q <= '0;
            z_out_q <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (enable) begin
                        x_q     <= x_ld;
                        y_q     <= y_ld;
                        z_q     <= z_ld;
                        op_q    <= mode_op;
                        coord_q <= coord_ld;
                        s_q     <= (coord_ld == COORD_HYP) ? 5'd1 : 5'd0;
                        rep_q   <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    x_q   <= x_d;
                    y_q   <= y_d;
                    z_q   <= z_d;
                    cnt_q <= cnt_q + 5'd1;
                    if (rep_now) begin
                        rep_q <= 1'b1;
                    end else begin
                        s_q   <= s_q + 5'd1;
                        rep_q <= 1'b0;
                    end
                    if (cnt_q == LAST_STEP) begin
                        state_q <= ST_COMP;
                    end
                end
                ST_COMP: begin
                    if (coord_q != COORD_LIN) begin
                        x_q <= x_sc;
                        y_q <= y_sc;
                    end
                    state_q <= ST_DONE;
                end
                default: begin
                    x_out_q <= x_q;
                    y_out_q <= y_q;
                    z_out_q <= z_q;
                    valid_q <= 1'b1;
                    cnt_q   <= '0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign x_out = x_out_q;
    assign y_out = y_out_q;
    assign z_out = z_out_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_cordic_core.sv
// Self-checking bench for cordic_core: directed table, random ops against a real-arithmetic model, control corners.
// Latency: n/a.
// Backpressure: n/a.
module tb_cordic_core;

    localparam int WIDTH = 32;
    localparam int ITER  = 16;
    localparam real SC   = 65536.0;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    enable;
    logic                    mode_op;
    logic        [1:0]       mode_coord;
    logic signed [WIDTH-1:0] x_in, y_in, z_in;
    logic signed [WIDTH-1:0] x_out, y_out, z_out;
    logic                    valid;

    int checks = 0;
    int errors = 0;

    cordic_core #(
        .WIDTH      (WIDTH),
        .ITERATIONS (ITER)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .mode_op    (mode_op),
        .mode_coord (mode_coord),
        .x_in       (x_in),
        .y_in       (y_in),
        .z_in       (z_in),
        .x_out      (x_out),
        .y_out      (y_out),
        .z_out      (z_out),
        .valid      (valid)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string      name;
        logic       op;
        logic [1:0] coord;
        int         x, y, z;
        int         ex, ey, ez;
    } vec_t;

    task automatic chk_near(input string name, input int act, input real exp, input int tol);
        real diff;
        checks++;
        diff = $itor(act) - exp;
        if (diff < 0.0) diff = -diff;
        if (diff > $itor(tol)) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d tol=%0d", name, act, $rtoi(exp), tol);
        end
    endtask

    task automatic chk_eq(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    // Ideal mathematical result of each mode, in Q16.16 LSBs.
    task automatic model(input logic op, input logic [1:0] coord, input int x, input int y, input int z,
                         output real ex, output real ey, output real ez);
        real fx, fy, fz;
        fx = $itor(x) / SC;
        fy = $itor(y) / SC;
        fz = $itor(z) / SC;
        case (coord)
            2'b00: begin
                if (op == 1'b0) begin ex = fx; ey = fy + fx * fz; ez = 0.0; end
                else            begin ex = fx; ey = 0.0;          ez = fz + fy / fx; end
            end
            2'b10: begin
                if (op == 1'b0) begin
                    ex = fx * $cosh(fz) + fy * $sinh(fz);
                    ey = fy * $cosh(fz) + fx * $sinh(fz);
                    ez = 0.0;
                end else begin
                    ex = $sqrt(fx * fx - fy * fy);
                    ey = 0.0;
                    ez = fz + $atanh(fy / fx);
                end
            end
            default: begin
                if (op == 1'b0) begin
                    ex = fx * $cos(fz) - fy * $sin(fz);
                    ey = fy * $cos(fz) + fx * $sin(fz);
                    ez = 0.0;
                end else begin
                    ex = $sqrt(fx * fx + fy * fy);
                    ey = 0.0;
                    ez = fz + $atan2(fy, fx);
                end
            end
        endcase
        ex = ex * SC;
        ey = ey * SC;
        ez = ez * SC;
    endtask

    // Start one operation, scramble the operand ports, and wait (bounded) for valid.
    task automatic run_op(input logic op, input logic [1:0] coord, input int x, input int y, input int z,
                          output int lat);
        @(posedge clk); #1;
        enable = 1'b1; mode_op = op; mode_coord = coord;
        x_in = x; y_in = y; z_in = z;
        @(posedge clk); #1;
        enable = 1'b0;
        x_in = $urandom; y_in = $urandom; z_in = $urandom;
        mode_op = $urandom_range(0, 1); mode_coord = 2'($urandom_range(0, 3));
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (valid) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic apply_check(input string name, input logic op, input logic [1:0] coord,
                               input int x, input int y, input int z,
                               input real ex, input real ey, input real ez, input int tol);
        int lat;
        run_op(op, coord, x, y, z, lat);
        chk_eq({name, ".latency"}, lat, ITER + 2);
        if (lat > 0) begin
            chk_near({name, ".x"}, x_out, ex, tol);
            chk_near({name, ".y"}, y_out, ey, tol);
            chk_near({name, ".z"}, z_out, ez, tol);
            @(posedge clk); #1;
            chk_eq({name, ".pulse"}, int'(valid), 0);
        end
    endtask

    function automatic int srange(input int r);
        return int'($urandom_range(0, 2 * r)) - r;
    endfunction

    initial begin
        vec_t tbl[$];
        real  ex, ey, ez;
        int   nval;
        int   vcyc[$];
        int   lat;

        tbl.push_back('{"rot_circ_45",  1'b0, 2'b01, 65536,  0,     51472,  46341, 46341, 0});
        tbl.push_back('{"vec_circ_45",  1'b1, 2'b01, 65536,  65536, 0,      92682, 0,     51472});
        tbl.push_back('{"rot_lin_mul",  1'b0, 2'b00, 131072, 0,     98304,  131072, 196608, 0});
        tbl.push_back('{"vec_lin_div",  1'b1, 2'b00, 131072, 65536, 0,      131072, 0,     32768});
        tbl.push_back('{"rot_hyp_0p5",  1'b0, 2'b10, 65536,  0,     32768,  73900, 34151, 0});
        tbl.push_back('{"vec_hyp_0p5",  1'b1, 2'b10, 65536,  32768, 0,      56756, 0,     35999});
        tbl.push_back('{"rot_circ_z0",  1'b0, 2'b01, 65536,  0,     0,      65536, 0,     0});
        tbl.push_back('{"rot_rsv_m45",  1'b0, 2'b11, 65536,  0,     -51472, 46341, -46341, 0});
        tbl.push_back('{"rot_lin_neg",  1'b0, 2'b00, 65536,  65536, -65536, 65536, 0,     0});
`ifdef QUADRANT_EXT_EN
        tbl.push_back('{"rot_circ_135", 1'b0, 2'b01, 65536,  0,     154416, -46341, 46341, 0});
        tbl.push_back('{"vec_circ_q2",  1'b1, 2'b01, -65536, 65536, 0,      92682, 0,     154416});
`endif

        rst = 1'b1; enable = 1'b0; mode_op = 1'b0; mode_coord = 2'b00;
        x_in = '0; y_in = '0; z_in = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_eq("reset.x", x_out, 0);
        chk_eq("reset.y", y_out, 0);
        chk_eq("reset.z", z_out, 0);
        chk_eq("reset.valid", int'(valid), 0);

        // Directed vectors.
        for (int i = 0; i < tbl.size(); i++) begin
            apply_check(tbl[i].name, tbl[i].op, tbl[i].coord, tbl[i].x, tbl[i].y, tbl[i].z,
                        $itor(tbl[i].ex), $itor(tbl[i].ey), $itor(tbl[i].ez), 16);
        end

        // Randomised in-range operations against the ideal model.
        for (int i = 0; i < 40; i++) begin
            logic       op;
            logic [1:0] coord;
            int         x, y, z, lim;
            op    = 1'($urandom_range(0, 1));
            coord = 2'($urandom_range(0, 3));
            case (coord)
                2'b00: begin
                    if (op == 1'b0) begin x = srange(98304); y = srange(65536); z = srange(124518); end
                    else begin
                        x = int'($urandom_range(32768, 98304)); lim = x * 9 / 5;
                        y = srange(lim); z = srange(16384);
                    end
                end
                2'b10: begin
                    if (op == 1'b0) begin x = srange(65536); y = srange(65536); z = srange(65536); end
                    else begin
                        x = int'($urandom_range(32768, 65536)); lim = x * 7 / 10;
                        y = srange(lim); z = srange(16384);
                    end
                end
                default: begin
                    if (op == 1'b0) begin x = srange(65536); y = srange(65536); z = srange(104858); end
                    else begin x = int'($urandom_range(6554, 65536)); y = srange(65536); z = srange(32768); end
                end
            endcase
            model(op, coord, x, y, z, ex, ey, ez);
            apply_check($sformatf("rand%0d_op%0d_c%0d", i, op, coord), op, coord, x, y, z, ex, ey, ez, 64);
        end

        // Reset in the middle of RUN: outputs clear, no valid ever appears.
        @(posedge clk); #1;
        enable = 1'b1; mode_op = 1'b0; mode_coord = 2'b01;
        x_in = 65536; y_in = 0; z_in = 51472;
        @(posedge clk); #1;
        enable = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk_eq("midrst.x", x_out, 0);
        chk_eq("midrst.y", y_out, 0);
        chk_eq("midrst.z", z_out, 0);
        nval = 0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            if (valid) nval++;
        end
        chk_eq("midrst.novalid", nval, 0);

        // Enable held during RUN with changing operands: one result, from the first operands.
        @(posedge clk); #1;
        enable = 1'b1; mode_op = 1'b0; mode_coord = 2'b01;
        x_in = 65536; y_in = 0; z_in = 51472;
        nval = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (c == 0) begin x_in = 0; y_in = 65536; z_in = -30000; end
            if (c == 8) enable = 1'b0;
            if (valid) begin
                nval++;
                chk_near("busyen.x", x_out, 46341.0, 16);
                chk_near("busyen.y", y_out, 46341.0, 16);
            end
        end
        chk_eq("busyen.onevalid", nval, 1);
        chk_near("busyen.hold", x_out, 46341.0, 16);

        // Enable held high: back-to-back retriggers, ITER+3 cycles apart.
        @(posedge clk); #1;
        enable = 1'b1; mode_op = 1'b1; mode_coord = 2'b00;
        x_in = 131072; y_in = 65536; z_in = 0;
        for (int c = 0; c < 80; c++) begin
            @(posedge clk); #1;
            if (valid) vcyc.push_back(c);
        end
        enable = 1'b0;
        chk_eq("retrig.count", vcyc.size(), 4);
        if (vcyc.size() >= 3) begin
            chk_eq("retrig.first", vcyc[0], ITER + 2);
            chk_eq("retrig.gap1", vcyc[1] - vcyc[0], ITER + 3);
            chk_eq("retrig.gap2", vcyc[2] - vcyc[1], ITER + 3);
        end
        chk_near("retrig.z", z_out, 32768.0, 16);
        repeat (25) @(posedge clk);

        // Reserved coord in vectoring behaves as circular.
        model(1'b1, 2'b01, 65536, 32768, 0, ex, ey, ez);
        run_op(1'b1, 2'b11, 65536, 32768, 0, lat);
        chk_eq("rsv_vec.latency", lat, ITER + 2);
        chk_near("rsv_vec.x", x_out, ex, 16);
        chk_near("rsv_vec.z", z_out, ez, 16);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
